// File: rtl/game_sequencer.sv
// Frame sequencer and game-state controller for the Flappy Bird design.
// Turns each vSync falling edge into ordered bird/pipe/check/apply steps and tracks the score.
module game_sequencer #(
  parameter int unsigned BIRD_X     = 150,
  parameter int unsigned BIRD_SIZE  = 20,
  parameter int unsigned PIPE_W     = 40,
  parameter int unsigned GAP_H      = 120,
  parameter int unsigned FLOOR_Y    = 460,
  parameter int unsigned DIE_FRAMES = 60
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Flap,
  input  logic        vSync,
  input  logic [9:0]  BirdY,
  input  logic [9:0]  PipeX1,
  input  logic [9:0]  PipeY1,
  input  logic [9:0]  PipeX2,
  input  logic [9:0]  PipeY2,
  output logic        GameRun,
  output logic        ClearReq,
  output logic        BirdStep,
  output logic        FlapReq,
  output logic        PipeStep,
  output logic        Lost,
  output logic [15:0] Score,
  output logic [1:0]  State
);

  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_PLAY = 2'b01, ST_DYING = 2'b10, ST_OVER = 2'b11} state_e;
  typedef enum logic [2:0] {PH_IDLE, PH_BIRD, PH_PIPE, PH_CHECK, PH_APPLY} phase_e;

  localparam int unsigned DW = (DIE_FRAMES > 1) ? $clog2(DIE_FRAMES) : 1;
  localparam logic [10:0] BX_L = 11'(BIRD_X);
  localparam logic [10:0] BX_R = 11'(BIRD_X + BIRD_SIZE);
  localparam logic [10:0] PW   = 11'(PIPE_W);
  localparam logic [10:0] BS   = 11'(BIRD_SIZE);
  localparam logic [10:0] GH   = 11'(GAP_H);
  localparam logic [10:0] FY   = 11'(FLOOR_Y);

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  logic [2:0]      start_q, flap_q, vs_q;
  logic            pend_q, pend_d;
  logic            passed1_q, passed1_d, passed2_q, passed2_d;
  logic            hit_q, hit_d, clr1_q, clr1_d, clr2_q, clr2_d;
  logic            clear_q, clear_d;
  logic [15:0]     score_q, score_d;
  logic [DW-1:0]   die_q, die_d;
  logic            start_ev, flap_ev, tick, inc1, inc2;

  // [1] is the synchronised level, [2] its previous value for edge detection
  assign start_ev = start_q[1] & ~start_q[2];
  assign flap_ev  = flap_q[1] & ~flap_q[2];
  assign tick     = ~vs_q[1] & vs_q[2];
  assign inc1     = clr1_q & ~passed1_q;
  assign inc2     = clr2_q & ~passed2_q;

  function automatic logic pipe_hit(input logic [9:0] px, input logic [9:0] py, input logic [9:0] by);
    logic [10:0] x, y, b;
    x = {1'b0, px};
    y = {1'b0, py};
    b = {1'b0, by};
    return (x < BX_R) && ((x + PW) > BX_L) && ((b < y) || ((b + BS) > (y + GH)));
  endfunction

  function automatic logic pipe_cleared(input logic [9:0] px);
    return ({1'b0, px} + PW) <= BX_L;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    if (v == 16'h9999) return v;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      start_q   <= '0;
      flap_q    <= '0;
      vs_q      <= '0;
      state_q   <= ST_IDLE;
      phase_q   <= PH_IDLE;
      pend_q    <= 1'b0;
      passed1_q <= 1'b0;
      passed2_q <= 1'b0;
      hit_q     <= 1'b0;
      clr1_q    <= 1'b0;
      clr2_q    <= 1'b0;
      clear_q   <= 1'b0;
      score_q   <= '0;
      die_q     <= '0;
    end else begin
      start_q   <= {start_q[1:0], Start};
      flap_q    <= {flap_q[1:0], Flap};
      vs_q      <= {vs_q[1:0], vSync};
      state_q   <= state_d;
      phase_q   <= phase_d;
      pend_q    <= pend_d;
      passed1_q <= passed1_d;
      passed2_q <= passed2_d;
      hit_q     <= hit_d;
      clr1_q    <= clr1_d;
      clr2_q    <= clr2_d;
      clear_q   <= clear_d;
      score_q   <= score_d;
      die_q     <= die_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    pend_d    = pend_q;
    passed1_d = passed1_q;
    passed2_d = passed2_q;
    hit_d     = hit_q;
    clr1_d    = clr1_q;
    clr2_d    = clr2_q;
    clear_d   = 1'b0;
    score_d   = score_q;
    die_d     = die_q;
    case (state_q)
      ST_IDLE: begin
        pend_d  = 1'b0;
        phase_d = PH_IDLE;
        if (start_ev) begin
          score_d   = '0;
          passed1_d = 1'b0;
          passed2_d = 1'b0;
          state_d   = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (flap_ev) pend_d = 1'b1;
        case (phase_q)
          PH_IDLE:  if (tick) phase_d = PH_BIRD;
          // a press landing on the bird strobe belongs to the next frame
          PH_BIRD: begin
            pend_d  = flap_ev;
            phase_d = PH_PIPE;
          end
          PH_PIPE:  phase_d = PH_CHECK;
          PH_CHECK: begin
            hit_d   = pipe_hit(PipeX1, PipeY1, BirdY) || pipe_hit(PipeX2, PipeY2, BirdY) ||
                      (({1'b0, BirdY} + BS) > FY);
            clr1_d  = pipe_cleared(PipeX1);
            clr2_d  = pipe_cleared(PipeX2);
            phase_d = PH_APPLY;
          end
          PH_APPLY: begin
            phase_d = PH_IDLE;
            if (hit_q) begin
              state_d = ST_DYING;
              die_d   = '0;
              pend_d  = 1'b0;
            end else begin
              passed1_d = clr1_q;
              passed2_d = clr2_q;
              if (inc1 && inc2)      score_d = bcd_inc(bcd_inc(score_q));
              else if (inc1 || inc2) score_d = bcd_inc(score_q);
            end
          end
          default:  phase_d = PH_IDLE;
        endcase
      end
      ST_DYING: begin
        pend_d = 1'b0;
        if (tick) begin
          if (die_q == DW'(DIE_FRAMES - 1)) state_d = ST_OVER;
          else                              die_d   = die_q + DW'(1);
        end
      end
      ST_OVER: begin
        pend_d = 1'b0;
        if (start_ev) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    GameRun  = (state_q == ST_PLAY);
    Lost     = (state_q == ST_DYING) || (state_q == ST_OVER);
    BirdStep = (state_q == ST_PLAY) && (phase_q == PH_BIRD);
    FlapReq  = BirdStep && pend_q;
    PipeStep = (state_q == ST_PLAY) && (phase_q == PH_PIPE);
    ClearReq = clear_q;
    Score    = score_q;
    State    = state_q;
  end

  ap_no_tick_while_busy: assert property (@(posedge Clk) disable iff (!Reset)
    !(tick && (phase_q != PH_IDLE)));

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: frame timing, flap merging, collision, scoring and game-state flow.
module tb_game_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Start, Flap, vSync;
  logic [9:0]  BirdY, PipeX1, PipeY1, PipeX2, PipeY2;
  logic        GameRun, ClearReq, BirdStep, FlapReq, PipeStep, Lost;
  logic [15:0] Score;
  logic [1:0]  State;

  int n_chk  = 0;
  int n_fail = 0;
  int bs_tot = 0;
  int ps_tot = 0;
  int fr_tot = 0;
  logic bs3, fr3, ps4;

  typedef struct {
    int          by, px1, py1, px2, py2;
    logic [1:0]  st;
    logic [15:0] sc;
  } vec_t;
  vec_t tbl[16];

  game_sequencer #(
    .BIRD_X(150), .BIRD_SIZE(20), .PIPE_W(40), .GAP_H(120), .FLOOR_Y(460), .DIE_FRAMES(60)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Flap(Flap), .vSync(vSync),
    .BirdY(BirdY), .PipeX1(PipeX1), .PipeY1(PipeY1), .PipeX2(PipeX2), .PipeY2(PipeY2),
    .GameRun(GameRun), .ClearReq(ClearReq), .BirdStep(BirdStep), .FlapReq(FlapReq),
    .PipeStep(PipeStep), .Lost(Lost), .Score(Score), .State(State)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    bs_tot = bs_tot + (BirdStep ? 1 : 0);
    ps_tot = ps_tot + (PipeStep ? 1 : 0);
    fr_tot = fr_tot + (FlapReq ? 1 : 0);
  end

  initial begin
    #1500us;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({GameRun, ClearReq, BirdStep, FlapReq, PipeStep, Lost, Score, State});
  endfunction

  // vSync low for one cycle; data presented the cycle after, held until the next call
  task automatic frame(input int by, input int px1, input int py1, input int px2, input int py2,
                       input logic flap);
    @(negedge Clk) vSync = 1'b0;
    @(negedge Clk) begin
      vSync = 1'b1;
      BirdY = 10'(by); PipeX1 = 10'(px1); PipeY1 = 10'(py1); PipeX2 = 10'(px2); PipeY2 = 10'(py2);
      Flap  = flap;
    end
    @(negedge Clk);
    @(negedge Clk) begin
      bs3 = BirdStep; fr3 = FlapReq; Flap = 1'b0;
    end
    @(negedge Clk) ps4 = PipeStep;
  endtask

  task automatic settle();
    repeat (3) @(negedge Clk);
  endtask

  task automatic press_start();
    @(negedge Clk) Start = 1'b1;
    @(negedge Clk);
    @(negedge Clk) Start = 1'b0;
    @(negedge Clk);
  endtask

  task automatic press_flap();
    @(negedge Clk) Flap = 1'b1;
    repeat (2) @(negedge Clk);
    Flap = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk) Reset = 1'b0;
    #1 chk("reset_outputs", all_outs(), 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic pair();
    frame(200, 200, 150, 200, 150, 1'b0);
    frame(200, 100, 150, 100, 150, 1'b0);
  endtask

  initial begin
    int b0, p0, f0;
    Reset = 1'b0; Start = 1'b0; Flap = 1'b0; vSync = 1'b1;
    BirdY = 10'd200; PipeX1 = 10'd600; PipeY1 = 10'd150; PipeX2 = 10'd600; PipeY2 = 10'd150;

    tbl[0]  = '{200, 200, 150, 600, 150, 2'b01, 16'h0000};
    tbl[1]  = '{200, 111, 150, 600, 150, 2'b01, 16'h0000};
    tbl[2]  = '{200, 110, 150, 600, 150, 2'b01, 16'h0001};
    tbl[3]  = '{200, 100, 150, 600, 150, 2'b01, 16'h0001};
    tbl[4]  = '{200, 640, 150, 600, 150, 2'b01, 16'h0001};
    tbl[5]  = '{200, 100, 150, 600, 150, 2'b01, 16'h0002};
    tbl[6]  = '{200, 640, 150, 100, 150, 2'b01, 16'h0003};
    tbl[7]  = '{200, 100, 150, 100, 150, 2'b01, 16'h0004};
    tbl[8]  = '{200, 200, 150, 200, 150, 2'b01, 16'h0004};
    tbl[9]  = '{200, 100, 150, 100, 150, 2'b01, 16'h0006};
    tbl[10] = '{150, 150, 150, 600, 150, 2'b01, 16'h0006};
    tbl[11] = '{250, 150, 150, 600, 150, 2'b01, 16'h0006};
    tbl[12] = '{200, 170,   0, 600, 150, 2'b01, 16'h0006};
    tbl[13] = '{200, 110,   0, 600, 150, 2'b01, 16'h0007};
    tbl[14] = '{440, 600, 150, 600, 150, 2'b01, 16'h0007};
    tbl[15] = '{200, 600, 150, 169,   0, 2'b10, 16'h0007};

    #1 chk("reset_outputs", all_outs(), 32'd0);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("idle_state", 32'(State), 32'd0);

    press_start();
    chk("start_state", 32'(State), 32'd1);
    chk("start_gamerun", 32'(GameRun), 32'd1);
    chk("start_score", 32'(Score), 32'h0000);
    b0 = bs_tot; p0 = ps_tot;
    repeat (6) @(negedge Clk);
    chk("no_strobe_before_vsync", 32'((bs_tot - b0) + (ps_tot - p0)), 32'd0);

    press_flap();
    press_flap();
    b0 = bs_tot; p0 = ps_tot; f0 = fr_tot;
    frame(200, 600, 150, 600, 150, 1'b0);
    settle();
    chk("birdstep_t+3", 32'(bs3), 32'd1);
    chk("flapreq_with_birdstep", 32'(fr3), 32'd1);
    chk("pipestep_t+4", 32'(ps4), 32'd1);
    chk("birdstep_count", 32'(bs_tot - b0), 32'd1);
    chk("pipestep_count", 32'(ps_tot - p0), 32'd1);
    chk("flapreq_count", 32'(fr_tot - f0), 32'd1);

    frame(200, 600, 150, 600, 150, 1'b1);
    settle();
    chk("flap_on_birdstep_not_now", 32'(fr3), 32'd0);
    frame(200, 600, 150, 600, 150, 1'b0);
    settle();
    chk("flap_on_birdstep_next", 32'(fr3), 32'd1);
    frame(200, 600, 150, 600, 150, 1'b0);
    settle();
    chk("no_flap_no_req", 32'(fr3), 32'd0);

    for (int i = 0; i < 16; i++) begin
      frame(tbl[i].by, tbl[i].px1, tbl[i].py1, tbl[i].px2, tbl[i].py2, 1'b0);
      settle();
      chk($sformatf("tbl%0d_state", i), 32'(State), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_score", i), 32'(Score), 32'(tbl[i].sc));
    end
    chk("dying_lost", 32'(Lost), 32'd1);
    chk("dying_gamerun", 32'(GameRun), 32'd0);

    b0 = bs_tot; p0 = ps_tot;
    for (int i = 0; i < 59; i++) frame(200, 600, 150, 600, 150, 1'b1);
    chk("dying_no_strobes", 32'((bs_tot - b0) + (ps_tot - p0)), 32'd0);
    chk("dying_after_59", 32'(State), 32'd2);
    frame(200, 600, 150, 600, 150, 1'b0);
    chk("over_after_60", 32'(State), 32'd3);
    chk("over_lost", 32'(Lost), 32'd1);

    press_start();
    chk("clearreq_pulse", 32'(ClearReq), 32'd1);
    chk("over_to_idle", 32'(State), 32'd0);
    chk("idle_lost", 32'(Lost), 32'd0);
    @(negedge Clk);
    chk("clearreq_one_cycle", 32'(ClearReq), 32'd0);
    chk("idle_score_held", 32'(Score), 32'h0007);

    press_start();
    chk("restart_score", 32'(Score), 32'h0000);
    frame(445, 100, 150, 600, 150, 1'b0);
    settle();
    chk("ground_hit_state", 32'(State), 32'd2);
    chk("ground_hit_no_inc", 32'(Score), 32'h0000);

    do_reset();
    press_start();
    for (int x = 300; x >= 100; x--) begin
      frame(200, x, 150, 600, 150, 1'b0);
      settle();
      chk($sformatf("sweep_x%0d", x), 32'(Score), (x <= 110) ? 32'h0001 : 32'h0000);
    end

    @(negedge Clk) vSync = 1'b0;
    @(negedge Clk) vSync = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    chk("abort_birdstep", 32'(BirdStep), 32'd1);
    p0 = ps_tot;
    Reset = 1'b0;
    #1 chk("abort_outputs", all_outs(), 32'd0);
    repeat (3) @(negedge Clk);
    chk("abort_no_pipestep", 32'(ps_tot - p0), 32'd0);
    chk("abort_outputs_held", all_outs(), 32'd0);
    Reset = 1'b1;
    @(negedge Clk);

    press_start();
    frame(200, 100, 150, 600, 150, 1'b0);
    for (int i = 0; i < 499; i++) pair();
    settle();
    chk("score_0999", 32'(Score), 32'h0999);
    frame(200, 200, 150, 600, 150, 1'b0);
    frame(200, 100, 150, 600, 150, 1'b0);
    settle();
    chk("score_1000", 32'(Score), 32'h1000);
    for (int i = 0; i < 4499; i++) pair();
    settle();
    chk("score_9998", 32'(Score), 32'h9998);
    pair();
    settle();
    chk("score_sat_from_9998", 32'(Score), 32'h9999);
    pair();
    settle();
    chk("score_sat_9999", 32'(Score), 32'h9999);
    chk("still_play", 32'(State), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
